// File: rtl/irq_controller_if.sv
// Request/ack/mask bundle between interrupt sources, the controller and the core.
// The slave modport is the controller side; master is the core/source side.
interface irq_controller_if #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 3
);
    logic [NUM_IRQ-1:0] irq_req;
    logic               nmi;
    logic               mask_we;
    logic [NUM_IRQ-1:0] mask_din;
    logic               int_ack;
    logic               int_done;
    logic               int_out;
    logic               int_nmi;
    logic [ID_W-1:0]    int_id;
    logic [31:0]        int_vec;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic               in_service;
    logic               nmi_active;

    modport slave (
        input  irq_req, nmi, mask_we, mask_din, int_ack, int_done,
        output int_out, int_nmi, int_id, int_vec, mask_q, pending_q, in_service, nmi_active
    );

    modport master (
        output irq_req, nmi, mask_we, mask_din, int_ack, int_done,
        input  int_out, int_nmi, int_id, int_vec, mask_q, pending_q, in_service, nmi_active
    );
endinterface

// File: rtl/irq_controller.sv
// Priority interrupt controller: edge-latched maskable sources plus one preempting NMI.
// Source edge at k -> registered request after k+1; request held until the core acks.
module irq_controller #(
    parameter int                 NUM_IRQ    = 8,
    parameter int                 ID_W       = 3,
    parameter logic [31:0]        VEC_BASE   = 32'h0000_0080,
    parameter logic [31:0]        VEC_STRIDE = 32'h0000_0008,
    parameter logic [31:0]        NMI_VEC    = 32'h0000_0040,
    parameter logic [NUM_IRQ-1:0] MASK_RST   = {NUM_IRQ{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    irq_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERVICE,
        ST_NMI_REQ,
        ST_NMI_SVC
    } state_t;

    state_t             state_q;
    logic               ret_svc_q;
    logic [31:0]        ret_vec_q;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic               nmi_prev_q;
    logic               nmi_pend_q, nmi_pend_d;
    logic               int_out_q;
    logic               int_nmi_q;
    logic [ID_W-1:0]    int_id_q;
    logic [31:0]        int_vec_q;
    logic               in_service_q;
    logic               nmi_active_q;

    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] pending_clr;
    logic [NUM_IRQ-1:0] eligible;
    logic               nmi_rise;
    logic               ack_req;
    logic               ack_nmi;
    logic               win_vld;
    logic [ID_W-1:0]    win_idx;
    logic [31:0]        win_vec;

    assign irq_rise    = bus.irq_req & ~irq_prev_q;
    assign nmi_rise    = bus.nmi & ~nmi_prev_q;
    assign ack_req     = (state_q == ST_REQ) && bus.int_ack;
    assign ack_nmi     = (state_q == ST_NMI_REQ) && bus.int_ack;
    assign pending_clr = ack_req ? (NUM_IRQ'(1) << int_id_q) : '0;
    // A fresh edge in the same cycle as the clear keeps the bit set.
    assign pending_d   = (pending_q & ~pending_clr) | irq_rise;
    assign nmi_pend_d  = (nmi_pend_q & ~ack_nmi) | nmi_rise;
    assign mask_d      = bus.mask_we ? bus.mask_din : mask_q;
    assign eligible    = pending_q & ~mask_q;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_vld = 1'b1;
                win_idx = ID_W'(i);
            end
        end
    end

    assign win_vec = VEC_BASE + 32'(win_idx) * VEC_STRIDE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ret_svc_q    <= 1'b0;
            ret_vec_q    <= '0;
            irq_prev_q   <= '0;
            pending_q    <= '0;
            mask_q       <= MASK_RST;
            nmi_prev_q   <= 1'b0;
            nmi_pend_q   <= 1'b0;
            int_out_q    <= 1'b0;
            int_nmi_q    <= 1'b0;
            int_id_q     <= '0;
            int_vec_q    <= '0;
            in_service_q <= 1'b0;
            nmi_active_q <= 1'b0;
        end else begin
            irq_prev_q <= bus.irq_req;
            nmi_prev_q <= bus.nmi;
            pending_q  <= pending_d;
            nmi_pend_q <= nmi_pend_d;
            mask_q     <= mask_d;

            case (state_q)
                ST_IDLE: begin
                    if (nmi_pend_q) begin
                        state_q   <= ST_NMI_REQ;
                        ret_svc_q <= 1'b0;
                        ret_vec_q <= int_vec_q;
                        int_out_q <= 1'b1;
                        int_nmi_q <= 1'b1;
                        int_vec_q <= NMI_VEC;
                    end else if (win_vld) begin
                        state_q   <= ST_REQ;
                        int_out_q <= 1'b1;
                        int_id_q  <= win_idx;
                        int_vec_q <= win_vec;
                    end
                end
                ST_REQ: begin
                    if (bus.int_ack) begin
                        state_q      <= ST_SERVICE;
                        int_out_q    <= 1'b0;
                        in_service_q <= 1'b1;
                    end else if (nmi_pend_q) begin
                        // Withdrawn request stays pending and is re-arbitrated from IDLE.
                        state_q   <= ST_NMI_REQ;
                        ret_svc_q <= 1'b0;
                        ret_vec_q <= int_vec_q;
                        int_nmi_q <= 1'b1;
                        int_vec_q <= NMI_VEC;
                    end
                end
                ST_SERVICE: begin
                    if (bus.int_done) begin
                        state_q      <= ST_IDLE;
                        in_service_q <= 1'b0;
                    end else if (nmi_pend_q) begin
                        state_q   <= ST_NMI_REQ;
                        ret_svc_q <= 1'b1;
                        ret_vec_q <= int_vec_q;
                        int_out_q <= 1'b1;
                        int_nmi_q <= 1'b1;
                        int_vec_q <= NMI_VEC;
                    end
                end
                ST_NMI_REQ: begin
                    if (bus.int_ack) begin
                        state_q      <= ST_NMI_SVC;
                        int_out_q    <= 1'b0;
                        int_nmi_q    <= 1'b0;
                        nmi_active_q <= 1'b1;
                    end
                end
                ST_NMI_SVC: begin
                    if (bus.int_done) begin
                        state_q      <= ret_svc_q ? ST_SERVICE : ST_IDLE;
                        nmi_active_q <= 1'b0;
                        int_vec_q    <= ret_vec_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.int_out    = int_out_q;
    assign bus.int_nmi    = int_nmi_q;
    assign bus.int_id     = int_id_q;
    assign bus.int_vec    = int_vec_q;
    assign bus.mask_q     = mask_q;
    assign bus.pending_q  = pending_q;
    assign bus.in_service = in_service_q;
    assign bus.nmi_active = nmi_active_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: presentations go through a scoreboard queue checked by a
// negedge monitor; status outputs are checked directly after each stimulus edge.
module tb_irq_controller;

    logic clk;
    logic reset;

    irq_controller_if #(.NUM_IRQ(8), .ID_W(3)) bus ();

    irq_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        nmi;
        logic [2:0]  id;
        logic [31:0] vec;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_pres(input logic nmi, input logic [2:0] id, input logic [31:0] vec);
        exp_t e;
        e.nmi = nmi;
        e.id  = id;
        e.vec = vec;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic ack_cycle();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
    endtask

    task automatic done_cycle();
        bus.int_done = 1'b1;
        tick();
        bus.int_done = 1'b0;
    endtask

    // Monitor: a new presentation is int_out rising, or the NMI flag changing while int_out stays high.
    initial begin
        logic prev_out;
        logic prev_nmi;
        exp_t got;
        exp_t e;
        prev_out = 1'b0;
        prev_nmi = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.int_out === 1'b1 && (prev_out !== 1'b1 || bus.int_nmi !== prev_nmi)) begin
                got = {bus.int_nmi, bus.int_id, bus.int_vec};
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected: got nmi=%0b id=%0d vec=0x%0h, expected no request",
                             got.nmi, got.id, got.vec);
                end else begin
                    e = sb_q.pop_front();
                    if (got !== e) begin
                        miscompares++;
                        $display("FAIL sb_pres: got nmi=%0b id=%0d vec=0x%0h, expected nmi=%0b id=%0d vec=0x%0h",
                                 got.nmi, got.id, got.vec, e.nmi, e.id, e.vec);
                    end
                end
            end
            prev_out = bus.int_out;
            prev_nmi = bus.int_nmi;
        end
    end

    initial begin
        reset        = 1'b1;
        bus.irq_req  = '0;
        bus.nmi      = 1'b0;
        bus.mask_we  = 1'b0;
        bus.mask_din = '0;
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b0;
        do_reset();

        // Reset state
        chk("rst_int_out", 32'(bus.int_out), 0);
        chk("rst_int_nmi", 32'(bus.int_nmi), 0);
        chk("rst_int_id", 32'(bus.int_id), 0);
        chk("rst_int_vec", bus.int_vec, 0);
        chk("rst_mask", 32'(bus.mask_q), 32'hFF);
        chk("rst_pending", 32'(bus.pending_q), 0);
        chk("rst_in_service", 32'(bus.in_service), 0);
        chk("rst_nmi_active", 32'(bus.nmi_active), 0);

        // 1: single source 5, two-edge latency
        bus.mask_we = 1'b1; bus.mask_din = 8'h00;
        tick();
        bus.mask_we = 1'b0;
        chk("t1_mask", 32'(bus.mask_q), 0);
        bus.irq_req = 8'h20;
        expect_pres(1'b0, 3'd5, 32'hA8);
        tick();
        bus.irq_req = 8'h00;
        chk("t1_pending", 32'(bus.pending_q), 32'h20);
        chk("t1_no_req_yet", 32'(bus.int_out), 0);
        tick();
        chk("t1_int_out", 32'(bus.int_out), 1);
        chk("t1_vec", bus.int_vec, 32'hA8);
        ack_cycle();
        chk("t1_in_service", 32'(bus.in_service), 1);
        chk("t1_out_dropped", 32'(bus.int_out), 0);
        chk("t1_pend_clr", 32'(bus.pending_q), 0);
        done_cycle();
        chk("t1_done", 32'(bus.in_service), 0);

        // 2: simultaneous 3 and 6 -> 3 first, then 6
        bus.irq_req = 8'h48;
        expect_pres(1'b0, 3'd3, 32'h98);
        expect_pres(1'b0, 3'd6, 32'hB0);
        tick();
        bus.irq_req = 8'h00;
        tick();
        chk("t2_id3", 32'(bus.int_id), 3);
        ack_cycle();
        chk("t2_pend6", 32'(bus.pending_q), 32'h40);
        done_cycle();
        chk("t2_gap", 32'(bus.int_out), 0);
        tick();
        chk("t2_id6", 32'(bus.int_id), 6);
        chk("t2_vec6", bus.int_vec, 32'hB0);
        ack_cycle();
        done_cycle();
        // Stray ack/done in IDLE are ignored
        bus.int_ack = 1'b1; bus.int_done = 1'b1;
        tick();
        bus.int_ack = 1'b0; bus.int_done = 1'b0;
        chk("t2_stray_out", 32'(bus.int_out), 0);
        chk("t2_stray_svc", 32'(bus.in_service), 0);

        // Line held high across reset counts as one new edge
        bus.irq_req = 8'h80;
        do_reset();
        tick();
        chk("hold_reset_edge", 32'(bus.pending_q), 32'h80);

        // 3: masked sources latch but do not request
        bus.irq_req = 8'h04;
        tick();
        bus.irq_req = 8'h00;
        tick();
        chk("t3_pending", 32'(bus.pending_q), 32'h84);
        chk("t3_masked", 32'(bus.int_out), 0);
        bus.mask_we = 1'b1; bus.mask_din = 8'h00;
        expect_pres(1'b0, 3'd2, 32'h90);
        expect_pres(1'b0, 3'd7, 32'hB8);
        tick();
        bus.mask_we = 1'b0;
        tick();
        chk("t3_id2", 32'(bus.int_id), 2);
        ack_cycle();
        done_cycle();
        tick();
        chk("t3_id7", 32'(bus.int_id), 7);
        ack_cycle();
        done_cycle();

        // 4: NMI preempts SERVICE of id 1
        bus.irq_req = 8'h02;
        expect_pres(1'b0, 3'd1, 32'h88);
        tick();
        bus.irq_req = 8'h00;
        tick();
        ack_cycle();
        bus.nmi = 1'b1;
        expect_pres(1'b1, 3'd1, 32'h40);
        tick();
        bus.nmi = 1'b0;
        tick();
        chk("t4_nmi", 32'(bus.int_nmi), 1);
        chk("t4_vec", bus.int_vec, 32'h40);
        chk("t4_insvc_held", 32'(bus.in_service), 1);
        ack_cycle();
        chk("t4_nmi_active", 32'(bus.nmi_active), 1);
        done_cycle();
        chk("t4_ret_id", 32'(bus.int_id), 1);
        chk("t4_ret_vec", bus.int_vec, 32'h88);
        chk("t4_ret_insvc", 32'(bus.in_service), 1);
        chk("t4_nmi_off", 32'(bus.nmi_active), 0);
        done_cycle();
        chk("t4_idle", 32'(bus.in_service), 0);

        // 5: NMI withdraws an unacked request for id 4
        bus.irq_req = 8'h10;
        expect_pres(1'b0, 3'd4, 32'hA0);
        tick();
        bus.irq_req = 8'h00;
        tick();
        bus.nmi = 1'b1;
        expect_pres(1'b1, 3'd4, 32'h40);
        tick();
        bus.nmi = 1'b0;
        tick();
        chk("t5_nmi", 32'(bus.int_nmi), 1);
        chk("t5_pend4", 32'(bus.pending_q), 32'h10);
        ack_cycle();
        expect_pres(1'b0, 3'd4, 32'hA0);
        done_cycle();
        tick();
        chk("t5_represent", 32'(bus.int_out), 1);
        chk("t5_vec", bus.int_vec, 32'hA0);
        ack_cycle();
        done_cycle();

        // 6: reset in NMI_SVC clears everything
        bus.nmi = 1'b1;
        expect_pres(1'b1, 3'd4, 32'h40);
        tick();
        bus.nmi = 1'b0;
        tick();
        ack_cycle();
        bus.irq_req = 8'h01;
        tick();
        bus.irq_req = 8'h00;
        chk("t6_in_nmi_svc", 32'(bus.nmi_active), 1);
        chk("t6_pend0", 32'(bus.pending_q), 32'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_nmi_active", 32'(bus.nmi_active), 0);
        chk("t6_pending", 32'(bus.pending_q), 0);
        chk("t6_mask", 32'(bus.mask_q), 32'hFF);
        chk("t6_vec", bus.int_vec, 0);
        chk("t6_id", 32'(bus.int_id), 0);
        tick();
        tick();
        tick();
        chk("t6_no_residue", 32'(bus.int_out), 0);

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
